// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: fetch sequencer for the 10-bit-instruction processor.
// Owns the program counter, addresses a combinational instruction ROM,
// registers the returned instruction for decode, applies redirects and
// stalls, and stops on the halt instruction. Start/Done handshake for the
// test harness.
//
// Ports:
//   Clk, Reset      rising-edge clock, asynchronous active-high reset
//   Start           begin execution at RESET_PC (sampled in IDLE/HALT only)
//   InstAddress     ROM address (= PC register)
//   InstIn          ROM data for InstAddress, same cycle
//   InstOut         registered instruction to decode
//   InstValid       InstOut holds a new instruction this cycle
//   Stall           downstream cannot accept; hold PC and InstOut
//   RedirectValid   taken branch/jump; RedirectTarget is the next address
//   Running, Done   state is RUN / state is HALT
//   CycleCount      RUN cycles since last Start
//
// Build option: define FETCH_CYCLE_COUNT_EN to build the saturating RUN
// cycle counter; otherwise CycleCount is tied to zero.
module inst_fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [2:0]  HALT_OP  = 3'b111
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  output logic [15:0] InstAddress,
  input  logic [9:0]  InstIn,
  output logic [9:0]  InstOut,
  output logic        InstValid,
  input  logic        Stall,
  input  logic        RedirectValid,
  input  logic [15:0] RedirectTarget,
  output logic        Running,
  output logic        Done,
  output logic [15:0] CycleCount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetchState_t;

  fetchState_t state, stateNext;
  logic [15:0] pc, pcNext;
  logic [9:0]  instOutQ, instOutNext;
  logic        instValidQ, instValidNext;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      instOutQ   <= '0;
      instValidQ <= 1'b0;
    end else begin
      state      <= stateNext;
      pc         <= pcNext;
      instOutQ   <= instOutNext;
      instValidQ <= instValidNext;
    end
  end

  always_comb begin
    stateNext     = state;
    pcNext        = pc;
    instOutNext   = instOutQ;
    instValidNext = 1'b0;
    unique case (state)
      IDLE, HALT: begin
        if (Start) begin
          stateNext = RUN;
          pcNext    = RESET_PC;
        end
      end
      RUN: begin
        // Redirect outranks stall and halt: whatever the ROM returned for
        // the current PC is on the wrong path and is dropped.
        if (RedirectValid) begin
          pcNext = RedirectTarget;
        end else if (!Stall) begin
          instOutNext   = InstIn;
          instValidNext = 1'b1;
          if (InstIn[9:7] == HALT_OP) begin
            stateNext = HALT;
          end else begin
            pcNext = pc + 16'd1;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign InstAddress = pc;
  assign InstOut     = instOutQ;
  assign InstValid   = instValidQ;
  assign Running     = (state == RUN);
  assign Done        = (state == HALT);

`ifdef FETCH_CYCLE_COUNT_EN
  logic [15:0] cycleCountQ;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cycleCountQ <= '0;
    end else if (state == RUN) begin
      if (cycleCountQ != '1) begin
        cycleCountQ <= cycleCountQ + 16'd1;
      end
    end else if (Start) begin
      cycleCountQ <= '0;
    end
  end

  assign CycleCount = cycleCountQ;
`else
  assign CycleCount = '0;
`endif

endmodule
